// File: rtl/vga_scan_out_pkg.sv
// Shared timing defaults, colour constants and TinyVGA PMOD bit layout for the VGA scan-out path.
package vga_scan_out_pkg;

   localparam int CNT_W = 32'd10;

   localparam int H_ACTIVE_DEF = 32'd640;
   localparam int H_FP_DEF     = 32'd16;
   localparam int H_SYNC_DEF   = 32'd96;
   localparam int H_BP_DEF     = 32'd48;
   localparam int V_ACTIVE_DEF = 32'd480;
   localparam int V_FP_DEF     = 32'd10;
   localparam int V_SYNC_DEF   = 32'd2;
   localparam int V_BP_DEF     = 32'd33;

   localparam logic [5:0] COLOR_BLACK = 6'b000000;

   // TinyVGA byte: {hs, B0, G0, R0, vs, B1, G1, R1}
   localparam int VGA_HS_BIT = 32'd7;
   localparam int VGA_B0_BIT = 32'd6;
   localparam int VGA_G0_BIT = 32'd5;
   localparam int VGA_R0_BIT = 32'd4;
   localparam int VGA_VS_BIT = 32'd3;
   localparam int VGA_B1_BIT = 32'd2;
   localparam int VGA_G1_BIT = 32'd1;
   localparam int VGA_R1_BIT = 32'd0;

   localparam logic [7:0] VGA_IDLE = 8'h88;

   // rgb is RRGGBB with the MSB of each pair being the "1" bit of that channel
   function automatic logic [7:0] tinyvga_pack(input logic hs_n, input logic vs_n,
                                               input logic [5:0] rgb);
      logic [7:0] b;
      b             = 8'h00;
      b[VGA_HS_BIT] = hs_n;
      b[VGA_VS_BIT] = vs_n;
      b[VGA_R1_BIT] = rgb[5];
      b[VGA_R0_BIT] = rgb[4];
      b[VGA_G1_BIT] = rgb[3];
      b[VGA_G0_BIT] = rgb[2];
      b[VGA_B1_BIT] = rgb[1];
      b[VGA_B0_BIT] = rgb[0];
      return b;
   endfunction

endpackage

// File: rtl/vga_scan_out_if.sv
// Pixel bus between the scan-out block (master) and the flag pattern multiplexer (slave).
interface vga_scan_out_if;
   import vga_scan_out_pkg::*;

   logic [5:0]       color;
   logic [CNT_W-1:0] pix_x;
   logic [CNT_W-1:0] pix_y;
   logic             display_on;
   logic [7:0]       frame;
   logic             frame_start;
   logic [2:0]       flag_sel;
   logic [7:0]       vga_out;

   modport master (
      input  color,
      output pix_x, pix_y, display_on, frame, frame_start, flag_sel, vga_out
   );

   modport slave (
      output color,
      input  pix_x, pix_y, display_on, frame, frame_start, flag_sel, vga_out
   );

endinterface

// File: rtl/vga_scan_out_hv_counter.sv
// Raster position counters with blanking, sync and frame-boundary decode.
module vga_scan_out_hv_counter
   import vga_scan_out_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
)
(
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic             display_on,
   output logic             hs_n,
   output logic             vs_n,
   output logic             frame_start,
   output logic             frame_wrap
);

   localparam logic [CNT_W-1:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 32'd1);
   localparam logic [CNT_W-1:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 32'd1);
   localparam logic [CNT_W-1:0] H_ACT_C  = 10'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C  = 10'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] pix_x_r;
   logic [CNT_W-1:0] pix_y_r;
   logic             line_end_s;
   logic             frame_end_s;

   // >= rather than == so a corrupted count recovers on the next edge instead of running to 1023
   always_comb begin
      line_end_s  = (pix_x_r >= H_LAST);
      frame_end_s = (pix_y_r >= V_LAST);
   end

   // Horizontal and vertical position counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_x_r <= 10'd0;
         pix_y_r <= 10'd0;
      end else if (line_end_s) begin
         pix_x_r <= 10'd0;
         if (frame_end_s) begin
            pix_y_r <= 10'd0;
         end else begin
            pix_y_r <= pix_y_r + 10'd1;
         end
      end else begin
         pix_x_r <= pix_x_r + 10'd1;
         if (pix_y_r > V_LAST) begin
            pix_y_r <= 10'd0;
         end
      end
   end

   // Position decode; syncs are active low
   always_comb begin
      display_on  = (pix_x_r < H_ACT_C) && (pix_y_r < V_ACT_C);
      hs_n        = !((pix_x_r >= HS_START) && (pix_x_r < HS_END));
      vs_n        = !((pix_y_r >= VS_START) && (pix_y_r < VS_END));
      frame_start = (pix_x_r == 10'd0) && (pix_y_r == 10'd0);
      frame_wrap  = line_end_s && frame_end_s;
   end

   assign pix_x = pix_x_r;
   assign pix_y = pix_y_r;

endmodule

// File: rtl/vga_scan_out.sv
// 640x480@60 scan-out: raster counters, registered TinyVGA PMOD byte, frame counter.
// Optional flag cycler enabled by defining VGA_FLAG_CYCLE_EN.
module vga_scan_out
   import vga_scan_out_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int H_FP        = H_FP_DEF,
   parameter int H_SYNC      = H_SYNC_DEF,
   parameter int H_BP        = H_BP_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int V_FP        = V_FP_DEF,
   parameter int V_SYNC      = V_SYNC_DEF,
   parameter int V_BP        = V_BP_DEF
`ifdef VGA_FLAG_CYCLE_EN
   ,
   parameter int NUM_FLAGS   = 32'd8,
   parameter int HOLD_FRAMES = 32'd180
`endif
)
(
   input  logic          clk,
   input  logic          reset,
   vga_scan_out_if.master bus
);

   logic [CNT_W-1:0] pix_x_s;
   logic [CNT_W-1:0] pix_y_s;
   logic             display_on_s;
   logic             hs_n_s;
   logic             vs_n_s;
   logic             frame_start_s;
   logic             frame_wrap_s;
   logic [5:0]       rgb_s;
   logic [7:0]       vga_out_r;
   logic [7:0]       frame_r;
   logic [2:0]       flag_sel_s;

   vga_scan_out_hv_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_hv (
      .clk         (clk),
      .reset       (reset),
      .pix_x       (pix_x_s),
      .pix_y       (pix_y_s),
      .display_on  (display_on_s),
      .hs_n        (hs_n_s),
      .vs_n        (vs_n_s),
      .frame_start (frame_start_s),
      .frame_wrap  (frame_wrap_s)
   );

   // Colour is blanked outside the active window; syncs pass through untouched
   always_comb begin
      if (display_on_s) begin
         rgb_s = bus.color;
      end else begin
         rgb_s = COLOR_BLACK;
      end
   end

   // Output byte lags the counters by one clock, keeping syncs aligned with their pixel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_out_r <= VGA_IDLE;
      end else begin
         vga_out_r <= tinyvga_pack(hs_n_s, vs_n_s, rgb_s);
      end
   end

   // Frame counter advances on the raster wrap edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_r <= 8'd0;
      end else if (frame_wrap_s) begin
         frame_r <= frame_r + 8'd1;
      end
   end

`ifdef VGA_FLAG_CYCLE_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 32'd1);
   localparam logic [2:0] FLAG_LAST = 3'(NUM_FLAGS - 32'd1);

   logic [7:0] hold_r;
   logic [2:0] flag_sel_r;

   // Flag changes only on the raster wrap, so a visible frame never mixes two flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_r     <= 8'd0;
         flag_sel_r <= 3'd0;
      end else if (frame_wrap_s) begin
         if (hold_r >= HOLD_LAST) begin
            hold_r <= 8'd0;
            if (flag_sel_r >= FLAG_LAST) begin
               flag_sel_r <= 3'd0;
            end else begin
               flag_sel_r <= flag_sel_r + 3'd1;
            end
         end else begin
            hold_r <= hold_r + 8'd1;
         end
      end
   end

   assign flag_sel_s = flag_sel_r;
`else
   assign flag_sel_s = 3'd0;
`endif

   assign bus.pix_x       = pix_x_s;
   assign bus.pix_y       = pix_y_s;
   assign bus.display_on  = display_on_s;
   assign bus.frame_start = frame_start_s;
   assign bus.frame       = frame_r;
   assign bus.flag_sel    = flag_sel_s;
   assign bus.vga_out     = vga_out_r;

endmodule
